// File: rtl/ex_div_unit_pkg.sv
// Shared definitions for the EX-stage iterative divider: data-bus width and FSM state encoding.
// Imported by ex_div_unit and ex_div_unit_div_step.
package ex_div_unit_pkg;

    localparam int DATA_BUS = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference when it is non-negative and report that as the quotient bit.
module ex_div_unit_div_step
    import ex_div_unit_pkg::*;
#(
    parameter int WIDTH = DATA_BUS
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             dividend_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           unused_rem_msb;

    // The partial remainder is always below the divisor, so its top bit is zero before a shift.
    assign unused_rem_msb = rem_i[WIDTH];

    always_comb begin
        // NOTE: every signal written here is assigned on every path, so no latch is inferred.
        shifted = {rem_i[WIDTH-1:0], dividend_bit_i};
        diff    = shifted - {1'b0, divisor_i};
        q_bit_o = ~diff[WIDTH];
        rem_o   = q_bit_o ? diff : shifted;
    end

endmodule

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle, stalls EX while busy.
// Optional macro EX_DIV_ZERO_FLAG_EN adds the div_zero_o flag port.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int WIDTH = DATA_BUS,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             ready_o,
    output logic             hilo_write_en_o,
    output logic             stall_req_o
`ifdef EX_DIV_ZERO_FLAG_EN
    ,
    output logic             div_zero_o
`endif
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic             quot_neg_q;
    logic             rem_neg_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             ready_q;
`ifdef EX_DIV_ZERO_FLAG_EN
    logic             div_zero_q;
`endif

    logic             op1_neg;
    logic             op2_neg;
    logic [WIDTH-1:0] op1_abs;
    logic [WIDTH-1:0] op2_abs;
    logic [WIDTH:0]   rem_d;
    logic             q_bit;
    logic [WIDTH-1:0] quot_d;
    logic             last_step;

    assign op1_neg   = signed_i & opdata1_i[WIDTH-1];
    assign op2_neg   = signed_i & opdata2_i[WIDTH-1];
    assign op1_abs   = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_abs   = op2_neg ? -opdata2_i : opdata2_i;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // The dividend register doubles as the quotient: each step shifts one dividend bit out and one quotient bit in.
    assign quot_d = {dvd_q[WIDTH-2:0], q_bit};

    ex_div_unit_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i          (rem_q),
        .dividend_bit_i (dvd_q[WIDTH-1]),
        .divisor_i      (dvs_q),
        .rem_o          (rem_d),
        .q_bit_o        (q_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            ready_q    <= 1'b0;
`ifdef EX_DIV_ZERO_FLAG_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            // Raw dividend is kept so the remainder reports it unmodified.
                            dvd_q   <= opdata1_i;
                            state_q <= DIV_ZERO;
                        end else begin
                            dvd_q      <= op1_abs;
                            dvs_q      <= op2_abs;
                            rem_q      <= '0;
                            quot_neg_q <= op1_neg ^ op2_neg;
                            rem_neg_q  <= op1_neg;
                            cnt_q      <= '0;
                            state_q    <= DIV_ON;
                        end
                    end
                end
                DIV_ZERO: begin
                    hi_q    <= dvd_q;
                    lo_q    <= '1;
                    ready_q <= 1'b1;
`ifdef EX_DIV_ZERO_FLAG_EN
                    div_zero_q <= 1'b1;
`endif
                    state_q <= DIV_END;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= quot_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_step) begin
                            lo_q    <= quot_neg_q ? -quot_d : quot_d;
                            hi_q    <= rem_neg_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
                            ready_q <= 1'b1;
                            state_q <= DIV_END;
                        end
                    end
                end
                DIV_END: begin
                    // Holding start_i keeps the result presented without relaunching.
                    if (!start_i || annul_i) begin
                        ready_q <= 1'b0;
`ifdef EX_DIV_ZERO_FLAG_EN
                        div_zero_q <= 1'b0;
`endif
                        state_q <= DIV_IDLE;
                    end
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    assign hi_o            = hi_q;
    assign lo_o            = lo_q;
    assign ready_o         = ready_q;
    assign hilo_write_en_o = ready_q & ~annul_i;
    assign stall_req_o     = start_i & ~ready_q & ~annul_i;
`ifdef EX_DIV_ZERO_FLAG_EN
    assign div_zero_o      = div_zero_q;
`endif

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: latency, results, div-by-zero, signed overflow, annul, async reset, END hold.
// Define EX_DIV_ZERO_FLAG_EN to also check div_zero_o.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        ready_o;
    logic        hilo_write_en_o;
    logic        stall_req_o;
`ifdef EX_DIV_ZERO_FLAG_EN
    logic        div_zero_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_div_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .signed_i        (signed_i),
        .annul_i         (annul_i),
        .opdata1_i       (opdata1_i),
        .opdata2_i       (opdata2_i),
        .hi_o            (hi_o),
        .lo_o            (lo_o),
        .ready_o         (ready_o),
        .hilo_write_en_o (hilo_write_en_o),
        .stall_req_o     (stall_req_o)
`ifdef EX_DIV_ZERO_FLAG_EN
        ,
        .div_zero_o      (div_zero_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launches one op in cycle 0 and measures the cycle in which ready_o rises.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input int hold);
        int   lat;
        logic stall_bad;
        @(negedge clk);
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        #1;
        stall_bad = ~stall_req_o;
        lat = 0;
        while (!ready_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (!ready_o && !stall_req_o) stall_bad = 1'b1;
            if (lat == 4) begin
                opdata1_i = 32'hDEAD_BEEF;
                opdata2_i = 32'h0000_0003;
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".hi"}, hi_o, exp_hi);
        check({tag, ".lo"}, lo_o, exp_lo);
        check({tag, ".hilo_we"}, 32'(hilo_write_en_o), 32'd1);
        check({tag, ".stall_end"}, 32'(stall_req_o), 32'd0);
        check({tag, ".stall_busy"}, 32'(stall_bad), 32'd0);
`ifdef EX_DIV_ZERO_FLAG_EN
        check({tag, ".div_zero"}, 32'(div_zero_o), 32'(exp_dz));
`else
        if (exp_dz === 1'bx) $display("note: %s", tag);
`endif
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            check({tag, ".hold_ready"}, 32'(ready_o), 32'd1);
            check({tag, ".hold_lo"}, lo_o, exp_lo);
            check({tag, ".hold_we"}, 32'(hilo_write_en_o), 32'd1);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".ready_drop"}, 32'(ready_o), 32'd0);
        check({tag, ".we_drop"}, 32'(hilo_write_en_o), 32'd0);
`ifdef EX_DIV_ZERO_FLAG_EN
        check({tag, ".dz_drop"}, 32'(div_zero_o), 32'd0);
`endif
    endtask

    initial begin
        logic seen_ready;
        rst       = 1'b0;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        annul_i   = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        #12;
        check("reset.ready", 32'(ready_o), 32'd0);
        check("reset.hi", hi_o, 32'd0);
        check("reset.lo", lo_o, 32'd0);
        check("reset.hilo_we", 32'(hilo_write_en_o), 32'd0);
`ifdef EX_DIV_ZERO_FLAG_EN
        check("reset.div_zero", 32'(div_zero_o), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 5);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33, 32'd1, 32'h7FFF_FFFC, 1'b0, 0);
        run_op("div_zero", 1'b0, 32'h0000_1234, 32'd0, 2, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 2);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0, 0);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b0, 0);

        // Annul partway through the iteration.
        @(negedge clk);
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        #1;
        check("annul.stall", 32'(stall_req_o), 32'd0);
        check("annul.we", 32'(hilo_write_en_o), 32'd0);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        seen_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen_ready = 1'b1;
        end
        check("annul.no_ready", 32'(seen_ready), 32'd0);
        run_op("after_annul", 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        signed_i  = 1'b0;
        opdata1_i = 32'd500;
        opdata2_i = 32'd9;
        start_i   = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("rst_mid.ready", 32'(ready_o), 32'd0);
        check("rst_mid.hi", hi_o, 32'd0);
        check("rst_mid.lo", lo_o, 32'd0);
        check("rst_mid.we", 32'(hilo_write_en_o), 32'd0);
        check("rst_mid.stall", 32'(stall_req_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen_ready = 1'b1;
        end
        check("rst_mid.no_ready", 32'(seen_ready), 32'd0);
        run_op("after_rst", 1'b0, 32'd500, 32'd9, 33, 32'd5, 32'd55, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
